// File: rtl/if_stage_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the IF stage top and its PC generator.
package if_stage_pkg;

  localparam int INST_W = 32;

  localparam logic [5:0]        OPC_HALT = 6'b010001;
  localparam logic [INST_W-1:0] NOP_WORD = '0;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    HALT
  } if_state_t;

  function automatic logic is_halt(
    input logic [INST_W-1:0] w,
    input logic [5:0]        opc
  );
    return w[31:26] == opc;
  endfunction

endpackage

// File: rtl/if_stage_pc_gen.sv
// Program counter register and next-PC select.
// Redirect load beats sequential advance; otherwise hold.
module if_stage_pc_gen
  import if_stage_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              adv,
  input  logic [INST_W-1:0] target,
  output logic [INST_W-1:0] pc,
  output logic [INST_W-1:0] pc_plus4
);

  logic [INST_W-1:0] pc_q;
  logic [INST_W-1:0] pc_d;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_q;
    if (load)
      pc_d = target;
    else if (adv)
      pc_d = pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (reset)
      pc_q <= RESET_PC;
    else
      pc_q <= pc_d;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: one outstanding imem request, stall parking,
// redirect with stale-response kill, and HALT detection.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC    = '0,
  parameter logic [5:0]        HALT_OPCODE = OPC_HALT,
  parameter logic [INST_W-1:0] NOP_INST    = NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_f_hz,
  input  logic              branch_taken_f_ex,
  input  logic [INST_W-1:0] branch_target_f_ex,
  output logic              imem_req,
  output logic [INST_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst_2_id,
  output logic [INST_W-1:0] pc4_out_2_id,
  output logic              halted,
  output logic [31:0]       inst_count
);

  if_state_t         state_q, state_d;
  logic              kill_q, kill_d;
  logic [INST_W-1:0] hold_q, hold_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [INST_W-1:0] pc4_q, pc4_d;
  logic [31:0]       cnt_q, cnt_d;

  logic              pc_load;
  logic              pc_adv;
  logic [INST_W-1:0] pc;
  logic [INST_W-1:0] pc_plus4;
  logic              dlv;
  logic [INST_W-1:0] dlv_word;

  if_stage_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .adv      (pc_adv),
    .target   (branch_target_f_ex),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  assign imem_req     = !reset && (state_q == FETCH);
  assign imem_addr    = pc;
  assign inst_2_id    = inst_q;
  assign pc4_out_2_id = pc4_q;
  assign halted       = (state_q == HALT);
  assign inst_count   = cnt_q;

  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    hold_d   = hold_q;
    inst_d   = stall_f_hz ? inst_q : NOP_INST;
    pc4_d    = pc4_q;
    cnt_d    = cnt_q;
    pc_load  = 1'b0;
    pc_adv   = 1'b0;
    dlv      = 1'b0;
    dlv_word = imem_rdata;

    if (branch_taken_f_ex) begin
      pc_load = 1'b1;
      inst_d  = NOP_INST;
      hold_d  = NOP_INST;
      kill_d  = 1'b0;
      state_d = FETCH;
      // a request still in flight must be drained before refetching
      if ((state_q == WAIT && !imem_rvalid) ||
          (state_q == FETCH && imem_gnt)) begin
        state_d = WAIT;
        kill_d  = 1'b1;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_gnt)
            state_d = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = FETCH;
            end else if (stall_f_hz) begin
              hold_d  = imem_rdata;
              state_d = HOLD;
            end else begin
              dlv = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!stall_f_hz) begin
            dlv      = 1'b1;
            dlv_word = hold_q;
          end
        end
        default: begin
        end
      endcase

      if (dlv) begin
        inst_d  = dlv_word;
        pc4_d   = pc_plus4;
        pc_adv  = 1'b1;
        cnt_d   = cnt_q + 32'd1;
        state_d = is_halt(dlv_word, HALT_OPCODE) ? HALT : FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      kill_q  <= 1'b0;
      hold_q  <= NOP_INST;
      inst_q  <= NOP_INST;
      pc4_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      hold_q  <= hold_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall park,
// redirect kill, HALT, PC wrap and reset during an outstanding fetch.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_f_hz = 1'b0;
  logic        branch_taken_f_ex = 1'b0;
  logic [31:0] branch_target_f_ex = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst_2_id;
  logic [31:0] pc4_out_2_id;
  logic        halted;
  logic [31:0] inst_count;

  int n_cmp = 0;
  int n_err = 0;

  if_stage dut (
    .clk                (clk),
    .reset              (reset),
    .stall_f_hz         (stall_f_hz),
    .branch_taken_f_ex  (branch_taken_f_ex),
    .branch_target_f_ex (branch_target_f_ex),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_gnt           (imem_gnt),
    .imem_rvalid        (imem_rvalid),
    .imem_rdata         (imem_rdata),
    .inst_2_id          (inst_2_id),
    .pc4_out_2_id       (pc4_out_2_id),
    .halted             (halted),
    .inst_count         (inst_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one request/grant then a 1-cycle response
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] w);
    n_cmp++;
    if (imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_req got=%b exp=1 addr=%h", imem_req, a);
    end
    n_cmp++;
    if (imem_addr !== a) begin
      n_err++;
      $display("FAIL fetch_addr got=%h exp=%h", imem_addr, a);
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = w;
    tick();
    imem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL rst_req got=%b exp=0", imem_req);
    end
    n_cmp++;
    if (inst_2_id !== 32'h0 || pc4_out_2_id !== 32'h0) begin
      n_err++;
      $display("FAIL rst_out got=%h/%h exp=0/0", inst_2_id, pc4_out_2_id);
    end
    n_cmp++;
    if (halted !== 1'b0 || inst_count !== 32'h0) begin
      n_err++;
      $display("FAIL rst_hc got=%b/%h exp=0/0", halted, inst_count);
    end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_seq();
    for (int i = 0; i < 3; i++) begin
      do_fetch(32'(4 * i), 32'h0000_1000 + 32'(i));
      n_cmp++;
      if (inst_2_id !== 32'h0000_1000 + 32'(i)) begin
        n_err++;
        $display("FAIL seq_inst got=%h exp=%h", inst_2_id, 32'h1000 + 32'(i));
      end
      n_cmp++;
      if (pc4_out_2_id !== 32'(4 * (i + 1))) begin
        n_err++;
        $display("FAIL seq_pc4 got=%h exp=%h", pc4_out_2_id, 32'(4 * (i + 1)));
      end
      n_cmp++;
      if (inst_count !== 32'(i + 1)) begin
        n_err++;
        $display("FAIL seq_cnt got=%0d exp=%0d", inst_count, i + 1);
      end
      if (i == 0) begin
        tick();
        n_cmp++;
        if (inst_2_id !== 32'h0 || pc4_out_2_id !== 32'h4) begin
          n_err++;
          $display("FAIL seq_bubble got=%h/%h exp=0/4", inst_2_id, pc4_out_2_id);
        end
      end
    end
  endtask

  task automatic test_stall();
    stall_f_hz = 1'b1;
    do_fetch(32'hC, 32'h0400_1234);
    n_cmp++;
    if (imem_req !== 1'b0 || inst_2_id !== 32'h0000_1002) begin
      n_err++;
      $display("FAIL stall_park got=%b/%h exp=0/00001002", imem_req, inst_2_id);
    end
    repeat (2) tick();
    n_cmp++;
    if (inst_2_id !== 32'h0000_1002 || pc4_out_2_id !== 32'hC) begin
      n_err++;
      $display("FAIL stall_frozen got=%h/%h exp=00001002/c", inst_2_id, pc4_out_2_id);
    end
    n_cmp++;
    if (inst_count !== 32'd3) begin
      n_err++; $display("FAIL stall_cnt got=%0d exp=3", inst_count);
    end
    stall_f_hz = 1'b0;
    tick();
    n_cmp++;
    if (inst_2_id !== 32'h0400_1234 || pc4_out_2_id !== 32'h10) begin
      n_err++;
      $display("FAIL stall_release got=%h/%h exp=04001234/10", inst_2_id, pc4_out_2_id);
    end
    n_cmp++;
    if (inst_count !== 32'd4) begin
      n_err++; $display("FAIL stall_rel_cnt got=%0d exp=4", inst_count);
    end
    tick();
    n_cmp++;
    if (inst_2_id !== 32'h0 || imem_addr !== 32'h10) begin
      n_err++;
      $display("FAIL stall_once got=%h/%h exp=0/10", inst_2_id, imem_addr);
    end
  endtask

  task automatic test_branch();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    branch_taken_f_ex = 1'b1;
    branch_target_f_ex = 32'h40;
    tick();
    branch_taken_f_ex = 1'b0;
    n_cmp++;
    if (inst_2_id !== 32'h0 || imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL br_wait got=%h/%b exp=0/0", inst_2_id, imem_req);
    end
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    n_cmp++;
    if (inst_2_id !== 32'h0 || inst_count !== 32'd4) begin
      n_err++;
      $display("FAIL br_drop got=%h/%0d exp=0/4", inst_2_id, inst_count);
    end
    do_fetch(32'h40, 32'h0000_2000);
    n_cmp++;
    if (inst_2_id !== 32'h2000 || pc4_out_2_id !== 32'h44 || inst_count !== 32'd5) begin
      n_err++;
      $display("FAIL br_target got=%h/%h/%0d exp=2000/44/5", inst_2_id, pc4_out_2_id, inst_count);
    end
  endtask

  task automatic test_halt();
    do_fetch(32'h44, 32'h4400_0000);
    n_cmp++;
    if (inst_2_id !== 32'h4400_0000 || halted !== 1'b1) begin
      n_err++;
      $display("FAIL halt_dlv got=%h/%b exp=44000000/1", inst_2_id, halted);
    end
    n_cmp++;
    if (pc4_out_2_id !== 32'h48 || inst_count !== 32'd6) begin
      n_err++;
      $display("FAIL halt_pc4 got=%h/%0d exp=48/6", pc4_out_2_id, inst_count);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (imem_req !== 1'b0) begin
        n_err++; $display("FAIL halt_req cyc=%0d got=%b exp=0", i, imem_req);
      end
    end
    n_cmp++;
    if (inst_2_id !== 32'h0 || halted !== 1'b1) begin
      n_err++;
      $display("FAIL halt_idle got=%h/%b exp=0/1", inst_2_id, halted);
    end
  endtask

  task automatic test_redirect_halt();
    branch_taken_f_ex = 1'b1;
    branch_target_f_ex = 32'h80;
    stall_f_hz = 1'b1;
    tick();
    branch_taken_f_ex = 1'b0;
    stall_f_hz = 1'b0;
    n_cmp++;
    if (halted !== 1'b0 || imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL rh_resume got=%b/%b exp=0/1", halted, imem_req);
    end
    do_fetch(32'h80, 32'h0000_3000);
    n_cmp++;
    if (inst_2_id !== 32'h3000 || pc4_out_2_id !== 32'h84 || inst_count !== 32'd7) begin
      n_err++;
      $display("FAIL rh_fetch got=%h/%h/%0d exp=3000/84/7", inst_2_id, pc4_out_2_id, inst_count);
    end
  endtask

  task automatic test_wrap();
    branch_taken_f_ex = 1'b1;
    branch_target_f_ex = 32'hFFFF_FFFC;
    tick();
    branch_taken_f_ex = 1'b0;
    do_fetch(32'hFFFF_FFFC, 32'h0000_4000);
    n_cmp++;
    if (inst_2_id !== 32'h4000 || pc4_out_2_id !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_pc4 got=%h/%h exp=4000/0", inst_2_id, pc4_out_2_id);
    end
    n_cmp++;
    if (imem_addr !== 32'h0 || inst_count !== 32'd8) begin
      n_err++;
      $display("FAIL wrap_addr got=%h/%0d exp=0/8", imem_addr, inst_count);
    end
  endtask

  task automatic test_reset_wait();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    reset = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0000_5555;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL rw_req got=%b exp=0", imem_req);
    end
    tick();
    reset = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    n_cmp++;
    if (inst_2_id !== 32'h0 || inst_count !== 32'd0 || pc4_out_2_id !== 32'h0) begin
      n_err++;
      $display("FAIL rw_state got=%h/%0d/%h exp=0/0/0", inst_2_id, inst_count, pc4_out_2_id);
    end
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0000_7777;
    tick();
    imem_rvalid = 1'b0;
    n_cmp++;
    if (inst_2_id !== 32'h0 || inst_count !== 32'd0) begin
      n_err++;
      $display("FAIL rw_late got=%h/%0d exp=0/0", inst_2_id, inst_count);
    end
    do_fetch(32'h0, 32'h0000_6000);
    n_cmp++;
    if (inst_2_id !== 32'h6000 || pc4_out_2_id !== 32'h4 || inst_count !== 32'd1) begin
      n_err++;
      $display("FAIL rw_fetch got=%h/%h/%0d exp=6000/4/1", inst_2_id, pc4_out_2_id, inst_count);
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_stall();
    test_branch();
    test_halt();
    test_redirect_halt();
    test_wrap();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
